// File: rtl/int_alu_seq.sv
// int_alu_seq: RV32I/RV64I integer/branch execute unit with valid/ready handshakes and an
// iterative shifter; define INT_ALU_BARREL_SHIFT_EN to use a single-cycle barrel shifter instead.
module int_alu_seq #(
  parameter int XLEN       = 32,
  parameter int SHAMT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mode,
  input  logic [2:0]      in_funct3,
  input  logic            in_alt,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_taken,
  output logic            out_illegal,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SL   = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  logic            accept;
  logic [SHW-1:0]  shamt;
  logic            lt_s, lt_u, eq;
  logic [XLEN-1:0] alu_res;
  logic            br_taken, br_illegal;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            taken_q, taken_d;
  logic            illegal_q, illegal_d;

`ifdef INT_ALU_BARREL_SHIFT_EN
  logic [XLEN-1:0] sra_in;

  assign sra_in   = $signed(in_a) >>> shamt;
  assign in_ready = !out_valid_q || out_ready;
  assign busy     = 1'b0;
`else
  localparam int SW1 = SHW + 1;
  localparam logic [SW1-1:0] STEP = SW1'(SHAMT_STEP);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e          state_q, state_d;
  logic [SHW-1:0]  rem_q, rem_d;
  logic            left_q, left_d;
  logic            arith_q, arith_d;
  logic            start_shift;
  logic [SW1-1:0]  rem_ext, step_amt;
  logic [XLEN-1:0] sra_step, shifted;

  assign in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign busy        = (state_q == SHIFT);
  assign start_shift = !in_mode && ((in_funct3 == F3_SL) || (in_funct3 == F3_SR)) && (shamt != '0);

  // One iteration: shift the working value by min(remaining, SHAMT_STEP).
  always_comb begin
    rem_ext  = {1'b0, rem_q};
    step_amt = (rem_ext < STEP) ? rem_ext : STEP;
    sra_step = $signed(result_q) >>> step_amt;
    shifted  = left_q ? (result_q << step_amt) : (arith_q ? sra_step : (result_q >> step_amt));
  end
`endif

  assign accept = in_valid && in_ready;
  assign shamt  = in_b[SHW-1:0];

  always_comb begin
    lt_s       = $signed(in_a) < $signed(in_b);
    lt_u       = in_a < in_b;
    eq         = in_a == in_b;
    alu_res    = '0;
    br_taken   = 1'b0;
    br_illegal = 1'b0;
    if (in_mode) begin
      case (in_funct3)
        3'b000:  br_taken = eq;
        3'b001:  br_taken = !eq;
        3'b100:  br_taken = lt_s;
        3'b101:  br_taken = !lt_s;
        3'b110:  br_taken = lt_u;
        3'b111:  br_taken = !lt_u;
        default: br_illegal = 1'b1;
      endcase
    end else begin
      case (in_funct3)
        F3_ADD:  alu_res = in_alt ? (in_a - in_b) : (in_a + in_b);
        F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
        F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
        F3_XOR:  alu_res = in_a ^ in_b;
        F3_OR:   alu_res = in_a | in_b;
        F3_AND:  alu_res = in_a & in_b;
`ifdef INT_ALU_BARREL_SHIFT_EN
        F3_SL:   alu_res = in_a << shamt;
        F3_SR:   alu_res = in_alt ? sra_in : (in_a >> shamt);
`else
        // Only shamt == 0 takes this path; non-zero shifts go through SHIFT.
        F3_SL:   alu_res = in_a;
        F3_SR:   alu_res = in_a;
`endif
        default: alu_res = '0;
      endcase
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    taken_d     = taken_q;
    illegal_d   = illegal_q;
`ifndef INT_ALU_BARREL_SHIFT_EN
    state_d     = state_q;
    rem_d       = rem_q;
    left_d      = left_q;
    arith_d     = arith_q;
    if (accept && start_shift) begin
      state_d   = SHIFT;
      rem_d     = shamt;
      left_d    = (in_funct3 == F3_SL);
      arith_d   = in_alt;
      result_d  = in_a;
      taken_d   = 1'b0;
      illegal_d = 1'b0;
    end else
`endif
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      taken_d     = br_taken;
      illegal_d   = br_illegal;
    end
`ifndef INT_ALU_BARREL_SHIFT_EN
    if (state_q == SHIFT) begin
      result_d = shifted;
      rem_d    = rem_q - step_amt[SHW-1:0];
      if (rem_d == '0) begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
`ifndef INT_ALU_BARREL_SHIFT_EN
      state_q     <= IDLE;
      rem_q       <= '0;
      left_q      <= 1'b0;
      arith_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      taken_q     <= taken_d;
      illegal_q   <= illegal_d;
`ifndef INT_ALU_BARREL_SHIFT_EN
      state_q     <= state_d;
      rem_q       <= rem_d;
      left_q      <= left_d;
      arith_q     <= arith_d;
`endif
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = result_q;
  assign out_taken   = taken_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_int_alu_seq.sv
// Directed self-checking bench for int_alu_seq: two instances (SHAMT_STEP 1 and 4) share stimulus.
module tb_int_alu_seq;

  localparam int XLEN = 32;
`ifdef INT_ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic            clk, rst;
  logic            in_valid, in_mode, in_alt, out_ready;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_a, in_b;

  logic            in_ready_1, out_valid_1, out_taken_1, out_illegal_1, busy_1;
  logic [XLEN-1:0] out_result_1;
  logic            in_ready_4, out_valid_4, out_taken_4, out_illegal_4, busy_4;
  logic [XLEN-1:0] out_result_4;

  int n_checks = 0;
  int n_fail   = 0;

  int_alu_seq #(.XLEN(XLEN), .SHAMT_STEP(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1), .in_mode(in_mode),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid_1), .out_ready(out_ready), .out_result(out_result_1),
    .out_taken(out_taken_1), .out_illegal(out_illegal_1), .busy(busy_1)
  );

  int_alu_seq #(.XLEN(XLEN), .SHAMT_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_4), .in_mode(in_mode),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid_4), .out_ready(out_ready), .out_result(out_result_4),
    .out_taken(out_taken_4), .out_illegal(out_illegal_4), .busy(busy_4)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        mode;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        taken;
    logic        illegal;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one shift from the post-edge slot and measure latency/busy on both instances.
  task automatic run_shift(input string name, input logic [2:0] f3, input logic alt,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                           input int lat1, input int lat4);
    int seen1, seen4, busy1_n, busy4_n;
    logic [31:0] r1, r4;
    seen1 = 0; seen4 = 0; busy1_n = 0; busy4_n = 0; r1 = '0; r4 = '0;
    check({name, "_idle4"}, in_ready_4, 1);
    in_valid = 1'b1; in_mode = 1'b0; in_funct3 = f3; in_alt = alt; in_a = a; in_b = b;
    out_ready = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (busy_1) busy1_n++;
      if (busy_4) busy4_n++;
      if (out_valid_1 && seen1 == 0) begin seen1 = cyc; r1 = out_result_1; end
      if (out_valid_4 && seen4 == 0) begin seen4 = cyc; r4 = out_result_4; end
    end
    check({name, "_lat_s1"},  seen1,   BARREL ? 1 : lat1);
    check({name, "_lat_s4"},  seen4,   BARREL ? 1 : lat4);
    check({name, "_busy_s1"}, busy1_n, BARREL ? 0 : lat1 - 1);
    check({name, "_busy_s4"}, busy4_n, BARREL ? 0 : lat4 - 1);
    check({name, "_res_s1"},  r1, exp);
    check({name, "_res_s4"},  r4, exp);
  endtask

  initial begin
    int nv, nr;
    vecs[0]  = '{"add_wrap",   1'b0, 3'b000, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
    vecs[1]  = '{"sub_wrap",   1'b0, 3'b000, 1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[2]  = '{"add_ovf",    1'b0, 3'b000, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0};
    vecs[3]  = '{"and_alt",    1'b0, 3'b111, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
    vecs[4]  = '{"or",         1'b0, 3'b110, 1'b0, 32'h0F0F0000, 32'h000F0F0F, 32'h0F0F0F0F, 1'b0, 1'b0};
    vecs[5]  = '{"xor",        1'b0, 3'b100, 1'b0, 32'hFFFF0000, 32'hF0F0F0F0, 32'h0F0FF0F0, 1'b0, 1'b0};
    vecs[6]  = '{"slt_neg",    1'b0, 3'b010, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0};
    vecs[7]  = '{"sltu_big",   1'b0, 3'b011, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[8]  = '{"slt_pos",    1'b0, 3'b010, 1'b0, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 1'b0};
    vecs[9]  = '{"sr_shamt0",  1'b0, 3'b101, 1'b0, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1'b0};
    vecs[10] = '{"sll_shamt0", 1'b0, 3'b001, 1'b1, 32'h0000ABCD, 32'h00000040, 32'h0000ABCD, 1'b0, 1'b0};
    vecs[11] = '{"beq",        1'b1, 3'b000, 1'b0, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0};
    vecs[12] = '{"bne",        1'b1, 3'b001, 1'b0, 32'h00000007, 32'h00000007, 32'h00000000, 1'b0, 1'b0};
    vecs[13] = '{"blt",        1'b1, 3'b100, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vecs[14] = '{"bltu",       1'b1, 3'b110, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[15] = '{"bge",        1'b1, 3'b101, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[16] = '{"bgeu",       1'b1, 3'b111, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vecs[17] = '{"br_f3_010",  1'b1, 3'b010, 1'b0, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b1};
    vecs[18] = '{"br_f3_011",  1'b1, 3'b011, 1'b0, 32'h00000001, 32'h00000002, 32'h00000000, 1'b0, 1'b1};

    clk = 1'b0; rst = 1'b1;
    in_valid = 1'b0; in_mode = 1'b0; in_funct3 = 3'b000; in_alt = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid",   out_valid_1,   0);
    check("rst_busy",        busy_1,        0);
    check("rst_out_result",  out_result_1,  0);
    check("rst_out_taken",   out_taken_1,   0);
    check("rst_out_illegal", out_illegal_1, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready_1, 1);
    @(posedge clk); #1;

    // Back-to-back table vectors with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      in_valid = 1'b1; in_mode = vecs[i].mode; in_funct3 = vecs[i].f3; in_alt = vecs[i].alt;
      in_a = vecs[i].a; in_b = vecs[i].b;
      #1;
      check({vecs[i].name, "_in_ready"}, in_ready_1, 1);
      @(posedge clk); #1;
      check({vecs[i].name, "_valid"},   out_valid_1,   1);
      check({vecs[i].name, "_result"},  out_result_1,  vecs[i].res);
      check({vecs[i].name, "_taken"},   out_taken_1,   vecs[i].taken);
      check({vecs[i].name, "_illegal"}, out_illegal_1, vecs[i].illegal);
      check({vecs[i].name, "_s4"}, {out_valid_4, out_result_4, out_taken_4, out_illegal_4},
            {1'b1, vecs[i].res, vecs[i].taken, vecs[i].illegal});
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("drain_valid_low", out_valid_1, 0);

    // Iterative shifts: latency = 1 + ceil(shamt/SHAMT_STEP)
    run_shift("sra5",  3'b101, 1'b1, 32'h80000000, 32'h00000025, 32'hFC000000, 6, 3);
    run_shift("sra8",  3'b101, 1'b1, 32'h80001234, 32'h00000008, 32'hFF800012, 9, 3);
    run_shift("srl4",  3'b101, 1'b0, 32'h80000000, 32'h00000004, 32'h08000000, 5, 2);
    run_shift("sll31", 3'b001, 1'b0, 32'h00000001, 32'h0000001F, 32'h80000000, 32, 9);

    // Backpressure: XOR result held for 5 cycles while another op is offered
    in_valid = 1'b1; in_mode = 1'b0; in_funct3 = 3'b100; in_alt = 1'b0;
    in_a = 32'hFF00FF00; in_b = 32'hF00FF00F; out_ready = 1'b0;
    @(posedge clk); #1;
    in_funct3 = 3'b000; in_a = 32'h00000002; in_b = 32'h00000003;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_valid",    out_valid_1,   1);
      check("bp_result",   out_result_1,  32'h0F0F0F0F);
      check("bp_taken",    {out_taken_1, out_illegal_1}, 0);
      check("bp_in_ready", in_ready_1,    0);
      @(posedge clk); #1;
    end
    check("bp_hold_end", out_result_1, 32'h0F0F0F0F);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready_1, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_b2b_valid",  out_valid_1,  1);
    check("bp_b2b_result", out_result_1, 32'h00000005);
    @(posedge clk); #1;
    check("bp_drain_valid", out_valid_1, 0);

    // Reset asserted in the middle of a long shift
    in_valid = 1'b1; in_mode = 1'b0; in_funct3 = 3'b001; in_alt = 1'b0;
    in_a = 32'h00000001; in_b = 32'h0000001F;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    check("mid_busy_before_rst",  busy_1,      BARREL ? 0 : 1);
    check("mid_valid_before_rst", out_valid_1, 0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_busy_async",   busy_1,       0);
    check("mid_valid_async",  out_valid_1,  0);
    check("mid_result_async", out_result_1, 0);
    check("mid_busy4_async",  busy_4,       0);
    @(posedge clk); #1;
    rst = 1'b0;
    nv = 0; nr = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (out_valid_1 || out_valid_4) nv++;
      if (!in_ready_1 || busy_1) nr++;
    end
    check("mid_no_result_after_rst", nv, 0);
    check("mid_ready_after_rst",     nr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
